// File: rtl/regbank_wb_ctrl.sv
// regbank_wb_ctrl: write-side initiator for the 32x32 register bank.
// Buffers writeback results from execute in a small FIFO and issues one
// registered bank write (wen/wport/din) per cycle. Writes to r0 are accepted
// but never enqueued, so r0 stays 0.
// Optional feature macro: REGBANK_WB_BYPASS_EN. When it is defined, pending
// values (FIFO entries plus the write currently on wport/din) are forwarded
// to the two snooped read ports. When it is undefined, the bypass outputs
// are tied to 0.
module regbank_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       flush,
  input  logic                       wr_hold,
  output logic                       wen,
  output logic [AW-1:0]              wport,
  output logic [DW-1:0]              din,
  input  logic [AW-1:0]              rport1,
  input  logic [AW-1:0]              rport2,
  output logic                       byp1_hit,
  output logic [DW-1:0]              byp1_data,
  output logic                       byp2_hit,
  output logic [DW-1:0]              byp2_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [AW-1:0] addr_mem_d [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [DW-1:0] data_mem_d [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] wport_q, wport_d;
  logic [DW-1:0] din_q, din_d;

  logic push;
  logic pop;
  logic accept;

  // in_ready comes from registered occupancy only, so a same-cycle pop never
  // opens a slot combinationally.
  assign in_ready = (count_q != CW'(DEPTH));
  assign accept   = in_valid && in_ready && !flush;
  assign push     = accept && (in_addr != '0);
  assign pop      = (count_q != '0) && !wr_hold && !flush;

  // Next-state for pointers, occupancy and the registered write port.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wen_d   = 1'b0;
    wport_d = wport_q;
    din_d   = din_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PW'(1);
      end
      if (pop) begin
        wen_d   = 1'b1;
        wport_d = addr_mem_q[head_q];
        din_d   = data_mem_q[head_q];
        head_d  = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Next contents of the entry storage: only the tail slot changes on a push.
  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      addr_mem_d[tail_q] = in_addr;
      data_mem_d[tail_q] = in_data;
    end
  end

  // Control and write-port registers; reset drops all pending writes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      wport_q <= '0;
      din_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wen_q   <= wen_d;
      wport_q <= wport_d;
      din_q   <= din_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign wen   = wen_q;
  assign wport = wport_q;
  assign din   = din_q;
  assign count = count_q;

`ifdef REGBANK_WB_BYPASS_EN
  // Scan the pending writes from oldest to youngest so the last match wins.
  // The in-flight write on wport/din is older than every FIFO entry.
  function automatic logic [DW:0] byp_search(input logic [AW-1:0] ra);
    logic [DW:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    if (ra != '0) begin
      if (wen_q && (wport_q == ra)) begin
        res = {1'b1, din_q};
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if ((CW'(i) < count_q) && (addr_mem_q[idx] == ra)) begin
          res = {1'b1, data_mem_q[idx]};
        end
      end
    end
    return res;
  endfunction

  // Forwarding lookup for read port 1.
  always_comb begin
    {byp1_hit, byp1_data} = byp_search(rport1);
  end

  // Forwarding lookup for read port 2.
  always_comb begin
    {byp2_hit, byp2_data} = byp_search(rport2);
  end
`else
  logic unused_rports;
  assign unused_rports = ^{rport1, rport2};
  assign byp1_hit  = 1'b0;
  assign byp1_data = '0;
  assign byp2_hit  = 1'b0;
  assign byp2_data = '0;
`endif

endmodule

// File: tb/tb_regbank_wb_ctrl.sv
// Bench for regbank_wb_ctrl: directed scenarios plus randomized traffic,
// compared against a queue-based model of the pending writes.
module tb_regbank_wb_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          wr_hold;
  logic          wen;
  logic [AW-1:0] wport;
  logic [DW-1:0] din;
  logic [AW-1:0] rport1;
  logic [AW-1:0] rport2;
  logic          byp1_hit;
  logic [DW-1:0] byp1_data;
  logic          byp2_hit;
  logic [DW-1:0] byp2_data;
  logic [CW-1:0] count;

  regbank_wb_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .flush(flush), .wr_hold(wr_hold),
    .wen(wen), .wport(wport), .din(din),
    .rport1(rport1), .rport2(rport2),
    .byp1_hit(byp1_hit), .byp1_data(byp1_data),
    .byp2_hit(byp2_hit), .byp2_data(byp2_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of pending {addr,data} plus the last bank write.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic          m_wen;
  logic [AW-1:0] m_wport;
  logic [DW-1:0] m_din;
  int            writes_seen;

  task automatic model_reset();
    mq.delete();
    m_wen   = 1'b0;
    m_wport = '0;
    m_din   = '0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    ent_t e;
    bit   ready;
    ready = (mq.size() != DEPTH);
    if (flush) begin
      mq.delete();
      m_wen = 1'b0;
    end else begin
      if (mq.size() > 0 && !wr_hold) begin
        e       = mq.pop_front();
        m_wen   = 1'b1;
        m_wport = e.a;
        m_din   = e.d;
      end else begin
        m_wen = 1'b0;
      end
      if (in_valid && ready && in_addr != 0) begin
        e.a = in_addr;
        e.d = in_data;
        mq.push_back(e);
      end
    end
  endtask

  function automatic logic [DW:0] model_byp(input logic [AW-1:0] ra);
    logic [DW:0] r;
    r = '0;
`ifdef REGBANK_WB_BYPASS_EN
    if (ra != 0) begin
      if (m_wen && m_wport == ra) r = {1'b1, m_din};
      foreach (mq[i]) if (mq[i].a == ra) r = {1'b1, mq[i].d};
    end
`endif
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [DW:0] b1;
    logic [DW:0] b2;
    b1 = model_byp(rport1);
    b2 = model_byp(rport2);
    check_eq({tag, "_count"}, 64'(count), 64'(mq.size()));
    check_eq({tag, "_ready"}, 64'(in_ready), 64'(mq.size() != DEPTH));
    check_eq({tag, "_wen"}, 64'(wen), 64'(m_wen));
    check_eq({tag, "_wport"}, 64'(wport), 64'(m_wport));
    check_eq({tag, "_din"}, 64'(din), 64'(m_din));
    check_eq({tag, "_b1hit"}, 64'(byp1_hit), 64'(b1[DW]));
    check_eq({tag, "_b1data"}, 64'(byp1_data), 64'(b1[DW-1:0]));
    check_eq({tag, "_b2hit"}, 64'(byp2_hit), 64'(b2[DW]));
    check_eq({tag, "_b2data"}, 64'(byp2_data), 64'(b2[DW-1:0]));
  endtask

  // Inputs are changed only at the falling edge, so the model sees them at posedge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    if (m_wen) writes_seen++;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    flush    = 1'b0;
    wr_hold  = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] pdata [4];
    rst_n  = 1'b0;
    rport1 = '0;
    rport2 = '0;
    idle_inputs();
    model_reset();
    writes_seen = 0;
    repeat (2) @(negedge clk);
    check_all("reset");
    check_eq("reset_wen", 64'(wen), 64'(0));
    check_eq("reset_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    tick("idle");

    // Single write: appears on the bank port after the second edge.
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'hA5;
    tick("t1_push");
    check_eq("t1_wen_early", 64'(wen), 64'(0));
    idle_inputs();
    tick("t1_pop");
    check_eq("t1_wen", 64'(wen), 64'(1));
    check_eq("t1_wport", 64'(wport), 64'(3));
    check_eq("t1_din", 64'(din), 64'(32'hA5));
    tick("t1_done");
    check_eq("t1_wen_off", 64'(wen), 64'(0));
    check_eq("t1_count", 64'(count), 64'(0));

    // Fill under hold, try a fifth push, then drain in order.
    wr_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = AW'(10 + i); pdata[i] = $urandom; in_data = pdata[i];
      tick("t2_fill");
    end
    in_addr = 5'd20; in_data = 32'hDEAD;
    tick("t2_full");
    check_eq("t2_count", 64'(count), 64'(4));
    check_eq("t2_ready", 64'(in_ready), 64'(0));
    check_eq("t2_wen", 64'(wen), 64'(0));
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick("t2_drain");
      check_eq("t2_dwen", 64'(wen), 64'(1));
      check_eq("t2_dwport", 64'(wport), 64'(10 + i));
      check_eq("t2_ddin", 64'(din), 64'(pdata[i]));
    end
    tick("t2_end");
    check_eq("t2_end_wen", 64'(wen), 64'(0));

    // r0 write is accepted but never reaches the bank.
    writes_seen = 0;
    in_valid = 1'b1; in_addr = '0; in_data = 32'h55;
    check_eq("t3_ready", 64'(in_ready), 64'(1));
    tick("t3_push");
    idle_inputs();
    repeat (3) tick("t3_wait");
    check_eq("t3_count", 64'(count), 64'(0));
    check_eq("t3_writes", 64'(writes_seen), 64'(0));

    // Two pending writes to r5: the younger value is forwarded.
    wr_hold = 1'b1;
    rport1 = 5'd5; rport2 = 5'd9;
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'd1;
    tick("t4_p1");
    in_data = 32'd2;
    tick("t4_p2");
`ifdef REGBANK_WB_BYPASS_EN
    check_eq("t4_hit", 64'(byp1_hit), 64'(1));
    check_eq("t4_data", 64'(byp1_data), 64'(2));
`else
    check_eq("t4_hit", 64'(byp1_hit), 64'(0));
    check_eq("t4_data", 64'(byp1_data), 64'(0));
`endif
    check_eq("t4_miss", 64'(byp2_hit), 64'(0));

    // Flush with three pending and a concurrent push: nothing is ever written.
    in_addr = 5'd7; in_data = 32'd7;
    tick("t5_p3");
    check_eq("t5_count3", 64'(count), 64'(3));
    writes_seen = 0;
    flush = 1'b1; in_addr = 5'd8; in_data = 32'd8;
    check_eq("t5_ready", 64'(in_ready), 64'(1));
    tick("t5_flush");
    check_eq("t5_count", 64'(count), 64'(0));
    check_eq("t5_wen", 64'(wen), 64'(0));
    idle_inputs();
    repeat (3) tick("t5_after");
    check_eq("t5_writes", 64'(writes_seen), 64'(0));

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr  = AW'($urandom_range(0, 7));
      in_data  = $urandom;
      wr_hold  = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 40) == 0);
      rport1   = AW'($urandom_range(0, 7));
      rport2   = AW'($urandom_range(0, 7));
      tick("rnd");
    end

    // Fill, start draining, then reset between edges.
    idle_inputs();
    wr_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = AW'(1 + i); in_data = $urandom;
      tick("t6_fill");
    end
    idle_inputs();
    tick("t6_pop");
    check_eq("t6_wen_pre", 64'(wen), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("t6_wen", 64'(wen), 64'(0));
    check_eq("t6_count", 64'(count), 64'(0));
    check_eq("t6_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    check_all("t6_rst");
    rst_n = 1'b1;
    repeat (3) tick("t6_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
